// File: rtl/adc_capture_ctrl.sv
// Dual-channel ADC frame capture: on a trigger, L consecutive A/B sample pairs
// are packed into 32-bit beats and streamed out through a small FIFO.
module adc_capture_ctrl #(
  parameter int DATA_W     = 14,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] adc_a_i,
  input  logic [DATA_W-1:0] adc_b_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  output logic [31:0]       m_tdata_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              m_tlast_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              trig_lost_o
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EXT = 16 - DATA_W;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             trig_lost_q, trig_lost_d;
  logic             busy_q, busy_d;

  logic [32:0]      mem [FIFO_DEPTH];
  logic [32:0]      rd_word;
  logic [31:0]      beat;
  logic             wr_req, wr_last, wr_ok, rd_fire, full;

  assign beat = {{{EXT{adc_a_i[DATA_W-1]}}, adc_a_i},
                 {{EXT{adc_b_i[DATA_W-1]}}, adc_b_i}};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    trig_lost_d = 1'b0;
    wr_req      = 1'b0;
    wr_last     = 1'b0;

    // Full is judged on the registered occupancy, so a same-cycle read never
    // makes room for a write.
    full    = (count_q == (AW+1)'(FIFO_DEPTH));
    rd_fire = (count_q != '0) && m_tready_i;

    case (state_q)
      IDLE: begin
        if (trig_i && (cfg_len_i != '0)) begin
          len_d   = cfg_len_i;
          cnt_d   = LEN_W'(1);
          wr_req  = 1'b1;
          wr_last = (cfg_len_i == LEN_W'(1));
          state_d = wr_last ? DRAIN : CAPTURE;
        end else begin
          trig_lost_d = trig_i;
        end
      end
      CAPTURE: begin
        trig_lost_d = trig_i;
        wr_req      = 1'b1;
        wr_last     = (cnt_q == len_q - LEN_W'(1));
        cnt_d       = cnt_q + LEN_W'(1);
        if (wr_last) state_d = DRAIN;
      end
      DRAIN: begin
        trig_lost_d = trig_i;
        if (count_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ok      = wr_req && !full;
    overflow_d = overflow_q | (wr_req & full);
    wr_ptr_d   = wr_ok   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_fire);
    busy_d     = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      trig_lost_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      trig_lost_q <= trig_lost_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the storage array is not reset; pointer/occupancy reset makes any
  // stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i) mem[wr_ptr_q] <= {wr_last, beat};
  end

  assign rd_word     = mem[rd_ptr_q];
  assign m_tvalid_o  = (count_q != '0);
  assign m_tdata_o   = m_tvalid_o ? rd_word[31:0] : 32'd0;
  assign m_tlast_o   = m_tvalid_o ? rd_word[32]   : 1'b0;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;
  assign trig_lost_o = trig_lost_q;

endmodule
